// File: rtl/lsu_bus_ctrl.sv
// MEM-stage load/store unit: one request/grant/response data-bus transaction per
// memory instruction, with byte-lane steering, load extension, misalign and timeout faults.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        mem_we_i,
  input  logic        mem_re_i,
  input  logic [2:0]  mem_size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_addr_i,
  output logic        stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        fault_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            we_q;
  logic            unsigned_q;
  logic [1:0]      size_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;

  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic        accept;
  logic        timeout_hit;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_data;

  always_comb begin
    // Sizes other than B/H decode as a word, including the reserved encodings.
    is_byte    = (mem_size_i[1:0] == 2'b00);
    is_half    = (mem_size_i[1:0] == 2'b01);
    misaligned = (is_half & addr_i[0]) | (~is_byte & ~is_half & (addr_i[1:0] != 2'b00));
    // The fault cycle lets the pipeline move on, so the faulting instruction is not retried.
    accept     = (state_q == StIdle) & req_valid_i & (mem_we_i | mem_re_i) & ~fault_o;

    if (is_byte) begin
      be_new    = 4'b0001 << addr_i[1:0];
      wdata_new = {4{wdata_i[7:0]}};
    end else if (is_half) begin
      be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{wdata_i[15:0]}};
    end else begin
      be_new    = 4'b1111;
      wdata_new = wdata_i;
    end
    if (!mem_we_i) wdata_new = '0;

    stall_o     = (accept & ~misaligned) | (state_q == StReq) | (state_q == StWait);
    timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
  end

  always_comb begin
    rbyte = bus_rdata_i[{off_q, 3'b000} +: 8];
    rhalf = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (size_q)
      2'b00:   load_data = unsigned_q ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   load_data = unsigned_q ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: load_data = bus_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_be_o     <= '0;
      bus_wdata_o  <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_addr_o <= 5'd0;
      wb_data_o    <= '0;
      misalign_o   <= 1'b0;
      fault_o      <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      fault_o    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (misaligned) begin
              misalign_o <= 1'b1;
            end else begin
              state_q     <= StReq;
              cnt_q       <= '0;
              we_q        <= mem_we_i;
              unsigned_q  <= mem_size_i[2];
              size_q      <= mem_size_i[1:0];
              off_q       <= addr_i[1:0];
              rd_q        <= rd_addr_i;
              bus_req_o   <= 1'b1;
              bus_we_o    <= mem_we_i;
              bus_addr_o  <= {addr_i[31:2], 2'b00};
              bus_be_o    <= be_new;
              bus_wdata_o <= wdata_new;
            end
          end
        end
        StReq: begin
          if (timeout_hit) begin
            state_q   <= StIdle;
            bus_req_o <= 1'b0;
            fault_o   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (bus_gnt_i) begin
              state_q   <= StWait;
              bus_req_o <= 1'b0;
            end
          end
        end
        StWait: begin
          if (timeout_hit) begin
            state_q <= StIdle;
            fault_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (bus_rvalid_i) begin
              state_q <= StDone;
              if (!we_q) begin
                wb_valid_o   <= (rd_q != 5'd0);
                wb_rd_addr_o <= rd_q;
                wb_data_o    <= load_data;
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: stimulus pushes expected bus requests and
// write-back/fault events into a scoreboard that a negedge monitor drains.
module tb_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, mem_we_i, mem_re_i;
  logic [2:0]  mem_size_i;
  logic [31:0] addr_i, wdata_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        misalign_o, fault_o;

  lsu_bus_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .mem_we_i(mem_we_i), .mem_re_i(mem_re_i),
    .mem_size_i(mem_size_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i),
    .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .wb_valid_o(wb_valid_o),
    .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o), .misalign_o(misalign_o),
    .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  typedef enum int {EvReq, EvWb, EvMis, EvFault} ev_e;
  typedef struct {
    ev_e         kind;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [4:0]  rd;
  } ev_t;

  ev_t sb[$];
  int  n_pass = 0;
  int  n_total = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic void push(ev_e kind, logic we, logic [31:0] addr, logic [3:0] be,
                               logic [31:0] data, logic [4:0] rd);
    ev_t e;
    e.kind = kind; e.we = we; e.addr = addr; e.be = be; e.data = data; e.rd = rd;
    sb.push_back(e);
  endfunction

  function automatic logic any_out();
    return stall_o | bus_req_o | bus_we_o | (|bus_addr_o) | (|bus_be_o) | (|bus_wdata_o) |
           wb_valid_o | (|wb_rd_addr_o) | (|wb_data_o) | misalign_o | fault_o;
  endfunction

  function automatic void observe(ev_e kind);
    ev_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_%s: got event, expected none", kind.name());
      return;
    end
    e = sb.pop_front();
    check("event_kind", kind, e.kind);
    if (e.kind != kind) return;
    if (kind == EvReq) begin
      check("req_we", bus_we_o, e.we);
      check("req_addr", bus_addr_o, e.addr);
      check("req_be", bus_be_o, e.be);
      check("req_wdata", bus_wdata_o, e.data);
    end else if (kind == EvWb) begin
      check("wb_rd", wb_rd_addr_o, e.rd);
      check("wb_data", wb_data_o, e.data);
    end
  endfunction

  // Monitor: one event per rising request and per output pulse.
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      req_prev = 1'b0;
    end else begin
      if (bus_req_o && !req_prev) observe(EvReq);
      req_prev = bus_req_o;
      if (wb_valid_o) observe(EvWb);
      if (misalign_o) observe(EvMis);
      if (fault_o) observe(EvFault);
    end
  end

  task automatic access(input logic we, input logic re, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                        input int exp_stall, input int exp_req, input string tag);
    int   stalls = 0;
    int   reqc = 0;
    int   waitc = 0;
    bit   granted = 0;
    bit   rv_done = 0;
    bit   done = 0;
    bit   stable = 1;
    logic [68:0] snap = '0;
    req_valid_i = 1'b1; mem_we_i = we; mem_re_i = re; mem_size_i = size;
    addr_i = addr; wdata_i = wdata; rd_addr_i = rd;
    for (int k = 0; k < 40 && !done; k++) begin
      bus_gnt_i    = bus_req_o && (reqc == gnt_dly) && !granted;
      bus_rvalid_i = granted && !rv_done && (waitc == rv_dly);
      bus_rdata_i  = bus_rvalid_i ? rdata : 32'h0;
      #1;
      if (stall_o) stalls++;
      else done = 1;
      if (bus_req_o) begin
        if (reqc == 0) snap = {bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o};
        else if (snap !== {bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o}) stable = 0;
        reqc++;
      end
      if (granted) waitc++;
      if (bus_gnt_i) granted = 1;
      if (bus_rvalid_i) rv_done = 1;
      @(posedge clk); #1;
      req_valid_i = 1'b0; mem_we_i = 1'b0; mem_re_i = 1'b0;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    end
    repeat (2) begin
      #1;
      if (bus_req_o) reqc++;
      @(posedge clk); #1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_stall_cycles"}, stalls, exp_stall);
    check({tag, "_req_cycles"}, reqc, exp_req);
    if (exp_req > 1) check({tag, "_req_stable"}, 32'(stable), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid_i = 0; mem_we_i = 0; mem_re_i = 0; mem_size_i = 3'b000;
    addr_i = '0; wdata_i = '0; rd_addr_i = '0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(any_out()), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LW zero-wait
    push(EvReq, 0, 32'h100, 4'hF, 32'h0, 0);
    push(EvWb, 0, 0, 0, 32'hDEADBEEF, 5'd5);
    access(0, 1, 3'b010, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF, 3, 1, "lw");

    // LB / LBU from the top byte lane
    push(EvReq, 0, 32'h100, 4'b1000, 32'h0, 0);
    push(EvWb, 0, 0, 0, 32'hFFFFFF80, 5'd6);
    access(0, 1, 3'b000, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80112233, 3, 1, "lb");
    push(EvReq, 0, 32'h100, 4'b1000, 32'h0, 0);
    push(EvWb, 0, 0, 0, 32'h00000080, 5'd7);
    access(0, 1, 3'b100, 32'h103, 32'h0, 5'd7, 0, 0, 32'h80112233, 3, 1, "lbu");

    // SH upper half, no write-back
    push(EvReq, 1, 32'h200, 4'b1100, 32'hABCDABCD, 0);
    access(1, 0, 3'b001, 32'h202, 32'h0000ABCD, 5'd8, 0, 0, 32'h0, 3, 1, "sh");

    // misaligned LW / SH / reserved size (word alignment)
    push(EvMis, 0, 0, 0, 0, 0);
    access(0, 1, 3'b010, 32'h101, 32'h0, 5'd9, 0, 0, 32'h0, 0, 0, "lw_mis");
    push(EvMis, 0, 0, 0, 0, 0);
    access(1, 0, 3'b001, 32'h203, 32'h1234, 5'd0, 0, 0, 32'h0, 0, 0, "sh_mis");
    push(EvMis, 0, 0, 0, 0, 0);
    access(0, 1, 3'b011, 32'h102, 32'h0, 5'd3, 0, 0, 32'h0, 0, 0, "rsv_mis");

    // LH with a slow grant (4 cycles) and response 2 cycles after grant
    push(EvReq, 0, 32'h100, 4'b1100, 32'h0, 0);
    push(EvWb, 0, 0, 0, 32'hFFFF8001, 5'd10);
    access(0, 1, 3'b001, 32'h102, 32'h0, 5'd10, 4, 1, 32'h80017FFF, 8, 5, "lh_slow");

    // SB lane 1, LHU lane 0, LW to x0, SW with both we/re set
    push(EvReq, 1, 32'h30, 4'b0010, 32'h78787878, 0);
    access(1, 0, 3'b000, 32'h31, 32'h12345678, 5'd1, 0, 0, 32'h0, 3, 1, "sb");
    push(EvReq, 0, 32'h200, 4'b0011, 32'h0, 0);
    push(EvWb, 0, 0, 0, 32'h0000F00D, 5'd31);
    access(0, 1, 3'b101, 32'h200, 32'h0, 5'd31, 0, 0, 32'h1234F00D, 3, 1, "lhu");
    push(EvReq, 0, 32'h10, 4'hF, 32'h0, 0);
    access(0, 1, 3'b010, 32'h10, 32'h0, 5'd0, 0, 0, 32'h55AA55AA, 3, 1, "lw_x0");
    push(EvReq, 1, 32'h40, 4'hF, 32'hCAFEF00D, 0);
    access(1, 1, 3'b010, 32'h40, 32'hCAFEF00D, 5'd2, 0, 0, 32'h0, 3, 1, "sw_we_re");

    // Timeout: never granted
    push(EvReq, 0, 32'h300, 4'hF, 32'h0, 0);
    push(EvFault, 0, 0, 0, 0, 0);
    access(0, 1, 3'b010, 32'h300, 32'h0, 5'd4, 99, 0, 32'h0, 9, 8, "timeout");
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h11111111;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    #1;
    check("late_rvalid_wb", 32'(wb_valid_o), 32'd0);
    check("late_rvalid_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;

    // Reset while waiting for the response
    push(EvReq, 0, 32'h400, 4'hF, 32'h0, 0);
    req_valid_i = 1'b1; mem_re_i = 1'b1; mem_size_i = 3'b010; addr_i = 32'h400; rd_addr_i = 5'd7;
    @(posedge clk); #1;
    req_valid_i = 1'b0; mem_re_i = 1'b0; bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    #1;
    check("wait_stall", 32'(stall_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_wait", 32'(any_out()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Recovery after reset
    push(EvReq, 0, 32'h500, 4'hF, 32'h0, 0);
    push(EvWb, 0, 0, 0, 32'h0BADF00D, 5'd12);
    access(0, 1, 3'b010, 32'h500, 32'h0, 5'd12, 0, 0, 32'h0BADF00D, 3, 1, "lw_after_rst");

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
